// File: rtl/bus_interconnect.sv
// Single-master, N-slave memory-mapped interconnect with base/mask address decode.
// Each transaction is routed to one slave; unmapped, illegal and timed-out accesses end in an error response.
module bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hA0000000, 32'h90000000, 32'h80000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hF0000000, 32'hF0000000, 32'hF0000000, 32'h80000000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           response,
  output logic                           error,
  output logic                           busy,
  output logic [NUM_SLAVES-1:0]          slave_read,
  output logic [NUM_SLAVES-1:0]          slave_write,
  output logic [ADDR_WIDTH-1:0]          slave_address,
  output logic [DATA_WIDTH-1:0]          slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]          slave_response
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_write;
  logic [IDX_W-1:0]      r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_req_one;
  logic                  w_req_both;
  logic                  w_sel_resp;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_timeout;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [DATA_WIDTH-1:0] w_slot_data [NUM_SLAVES];

  // Scan from the top index down so the lowest matching window is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_slot_data[i] = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_sel] = 1'b1;
  end

  assign w_req_one  = read ^ write;
  assign w_req_both = read & write;
  assign w_sel_resp = slave_response[r_sel];
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_both)     w_next = RESPOND;
        else if (w_req_one) w_next = w_hit ? ACCESS : RESPOND;
      end
      ACCESS:  if (w_sel_resp || w_timeout) w_next = RESPOND;
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_one) begin
            r_addr     <= address;
            r_wdata    <= write_data;
            r_is_write <= write;
            r_sel      <= w_idx;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= ~w_hit;
          end else if (w_req_both) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        ACCESS: begin
          // A real response wins over a timeout landing in the same cycle.
          if (w_sel_resp) begin
            r_rdata <= r_is_write ? '0 : w_slot_data[r_sel];
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
          r_cnt <= w_cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  assign response         = (r_state == RESPOND);
  assign read_data        = response ? r_rdata : '0;
  assign error            = response & r_err;
  assign busy             = (r_state != IDLE);
  assign slave_read       = (r_state == ACCESS && !r_is_write) ? w_onehot : '0;
  assign slave_write      = (r_state == ACCESS &&  r_is_write) ? w_onehot : '0;
  assign slave_address    = r_addr;
  assign slave_write_data = r_wdata;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: stimulus pushes expected responses, a monitor pops and compares.
module tb_bus_interconnect;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              read;
  logic              write;
  logic [AW-1:0]     address;
  logic [DW-1:0]     write_data;
  logic [DW-1:0]     read_data;
  logic              response;
  logic              error;
  logic              busy;
  logic [NS-1:0]     slave_read;
  logic [NS-1:0]     slave_write;
  logic [AW-1:0]     slave_address;
  logic [DW-1:0]     slave_write_data;
  logic [NS*DW-1:0]  slave_read_data;
  logic [NS-1:0]     slave_response;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW:0] exp_q [$];

  always #5 clk = ~clk;

  bus_interconnect #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .write_data(write_data), .read_data(read_data), .response(response), .error(error),
    .busy(busy), .slave_read(slave_read), .slave_write(slave_write),
    .slave_address(slave_address), .slave_write_data(slave_write_data),
    .slave_read_data(slave_read_data), .slave_response(slave_response)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation; otherwise data/error stay 0.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (response === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: got response with data %0h error %0b, expected none", read_data, error);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", read_data, e[DW-1:0]);
          chk("resp_error", error, e[DW]);
        end
      end else begin
        chk("idle_data", read_data, 0);
        chk("idle_error", error, 0);
      end
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int rs, input int dly, input logic [DW-1:0] sd, input int spur,
                         input logic [NS-1:0] exp_r, input logic [NS-1:0] exp_w, input int exp_n,
                         input logic [DW-1:0] exp_data, input logic exp_err);
    int n;
    int lat;
    bit done;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk); #1;
    read = rd; write = wr; address = a; write_data = wd;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; address = ~a; write_data = ~wd;
    n = 0; lat = 1; done = 1'b0;
    while (lat <= 40 && !done) begin
      @(negedge clk);
      chk("busy", busy, 1);
      if (response) begin
        done = 1'b1;
        chk("strobe_cycles", n, exp_n);
        chk("latency", lat, exp_n + 1);
        slave_response = '0;
      end else begin
        n++;
        chk("slave_read", slave_read, exp_r);
        chk("slave_write", slave_write, exp_w);
        chk("slave_address", slave_address, a);
        chk("slave_write_data", slave_write_data, wd);
        if (spur >= 0) slave_response[spur] = (n == 1);
        if (rs >= 0 && n == dly) begin
          slave_response[rs] = 1'b1;
          slave_read_data[rs*DW +: DW] = sd;
        end
      end
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: got no response within 40 cycles, expected a response at %0h", a);
      slave_response = '0;
    end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    slave_response = '0;
    slave_read_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0F0F0F0F};
    #1;
    chk("rst_slave_read", slave_read, 0);
    chk("rst_slave_write", slave_write, 0);
    chk("rst_response", response, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slave_address", slave_address, 0);
    chk("rst_slave_wdata", slave_write_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_txn(1, 0, 32'h00001000, 32'h0,        0, 3, 32'h12345678, -1, 4'b0001, 4'b0000, 3, 32'h12345678, 0);
    run_txn(0, 1, 32'h90000004, 32'hCAFEBABE, 2, 1, 32'hFFFF0000, -1, 4'b0000, 4'b0100, 1, 32'h0,        0);
    run_txn(1, 0, 32'hB0000000, 32'h0,       -1, 0, 32'h0,        -1, 4'b0000, 4'b0000, 0, 32'h0,        1);
    run_txn(1, 0, 32'h80000010, 32'h0,       -1, 0, 32'h0,        -1, 4'b0010, 4'b0000, 8, 32'h0,        1);
    run_txn(1, 1, 32'h00000000, 32'h0,       -1, 0, 32'h0,        -1, 4'b0000, 4'b0000, 0, 32'h0,        1);
    run_txn(1, 0, 32'h00000000, 32'h0,        0, 2, 32'h0BADF00D,  3, 4'b0001, 4'b0000, 2, 32'h0BADF00D, 0);
    run_txn(1, 0, 32'h90000100, 32'h0,        2, 1, 32'h77778888, -1, 4'b0100, 4'b0000, 1, 32'h77778888, 0);

    // Reset in the middle of an access to slave 3: strobe drops at once, no response.
    @(posedge clk); #1;
    read = 1'b1; address = 32'hA0000000;
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    chk("pre_rst_strobe", slave_read, 4'b1000);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobe", slave_read, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_response", response, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_txn(1, 0, 32'hA0000000, 32'h0, 3, 2, 32'h5A5A5A5A, -1, 4'b1000, 4'b0000, 2, 32'h5A5A5A5A, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
